mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-requester arbiter between the instruction-fetch cache and the data cache on one side and the single shared `proc2mem`/`mem2proc` bus on the other. It sits at the processor's memory boundary, directly upstream of the memory model. Each cycle it grants at most one command onto the bus, using round-robin priority. It records which requester owns each outstanding load tag, so that tagged data returns are routed back to the correct cache.

## Interface
- `NUM_TAGS`, default 15: valid memory tags are 1..`NUM_TAGS`; tag 0 means "none / rejected".
- `clock` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `ic2arb_command` input 2: icache request; BUS_NONE / BUS_LOAD / BUS_STORE.
- `ic2arb_addr` input `XLEN`: icache address.
- `ic2arb_data` input 64: icache store data (unused in practice).
- `arb2ic_response` output 4: tag assigned to the icache request this cycle; 0 if rejected or not granted.
- `arb2ic_data` output 64: returned load data for icache.
- `arb2ic_tag` output 4: tag of returned data owned by icache, else 0.
- `dc2arb_command`, `dc2arb_addr`, `dc2arb_data`: inputs, same widths, dcache request.
- `arb2dc_response`, `arb2dc_data`, `arb2dc_tag`: outputs, same widths, dcache side.
- `proc2mem_command` output 2, `proc2mem_addr` output `XLEN`, `proc2mem_data` output 64: granted command to memory.
- `mem2proc_response` input 4, `mem2proc_data` input 64, `mem2proc_tag` input 4: memory acceptance tag, return data, return tag.
- `arb_outstanding` output 5: registered count of outstanding load tags.
- `arb_tag_error` output 1: sticky flag; set by an unknown return tag.

## Operation
- **Request.** A requester is requesting when its command is not BUS_NONE.
- **Grant selection** (combinational):
  - Exactly one requester is requesting: it is granted.
  - Both are requesting: grant the requester that is not `last_grant`.
  - Neither: drive BUS_NONE with addr/data = 0.
- **Bus drive.** The granted requester's command, addr and data are driven onto `proc2mem_*`.
- **Acceptance.** `mem2proc_response` is passed to the granted requester's `arb2*_response`. The non-granted requester sees 0 and must hold its request.
- **Accepted** means granted and `mem2proc_response != 0`. On an accepted request:
  - `last_grant` <= granted requester.
  - For BUS_LOAD only: `owner_valid[tag]` <= 1 and `owner_id[tag]` <= requester (0 = ic, 1 = dc).
  - Stores allocate no entry.
- **Rejected grant** (response 0): `last_grant` is unchanged, so the same requester wins the next tie. Rejection stalls that requester; it does not starve the other.
- **Return routing** (combinational). When `mem2proc_tag != 0` and `owner_valid[tag]` = 1:
  - Data and tag go to the owner's `arb2*_data`/`arb2*_tag`.
  - The other side sees tag 0; data for both sides is `mem2proc_data`.
  - Next edge: `owner_valid[tag]` <= 0.
- **Unknown return.** `mem2proc_tag != 0` with `owner_valid[tag]` = 0: returned to neither side, and `arb_tag_error` <= 1.
- **Same-tag free and reuse in one cycle.** If the tag being freed equals the newly accepted tag: the allocate wins, so the entry stays valid with the new owner.
- **Outstanding count.** `arb_outstanding` <= `arb_outstanding` + (load accepted) − (valid return). The count is 0..15 and never wraps.

## Timing
- Grant, response pass-through and return routing are zero-latency (same cycle).
- The owner table, `last_grant`, `arb_outstanding` and `arb_tag_error` update at the posedge.
- Reset (synchronous) clears:
  - all `owner_valid`;
  - `last_grant` = ic, so dcache wins the first tie;
  - `arb_outstanding` = 0;
  - `arb_tag_error` = 0.
- While `reset` is high, all outputs are forced to 0 / BUS_NONE:
  - `proc2mem_command` = BUS_NONE, addr/data = 0;
  - `arb2*_response` = 0, `arb2*_tag` = 0, `arb2*_data` = 0.
- Reset during outstanding loads discards all entries. Later returns of those tags set `arb_tag_error`.

## Test plan
1. Icache only: BUS_LOAD at addr 0x100, mem response 3; later mem tag 3 with data 0xDEAD → `arb2ic_response` = 3 that cycle, `arb2ic_tag` = 3 and `arb2ic_data` = 0xDEAD at return, `arb2dc_tag` = 0, `arb_outstanding` 0→1→0.
2. Both request loads every cycle after reset, responses 1, 2, 3, 4 → grants in order dc, ic, dc, ic; each data return goes to the matching side.
3. Both request, mem response 0 for 3 cycles, then 5 → dc is granted all 4 cycles; ic response is 0 throughout; `last_grant` flips to dc only after acceptance.
4. Dcache BUS_STORE accepted with tag 7, followed by a return with tag 7 → no table entry; `arb_tag_error` = 1; neither `arb2*_tag` is nonzero.
5. Load tag 2 returns in the same cycle that a new icache load is accepted with tag 2 → entry 2 remains valid, owner ic; `arb_outstanding` unchanged.
6. 15 dcache loads accepted (tags 1..15), then reset asserted for 1 cycle → `arb_outstanding` = 0; outputs BUS_NONE/0 during reset; the first tie after reset goes to dc.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Round-robin arbiter of icache/dcache onto one tagged memory bus,
//            routing tagged load returns back to the owning cache.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int XLEN     = 32,
  parameter int NUM_TAGS = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      ic2arb_command,
  input  logic [XLEN-1:0] ic2arb_addr,
  input  logic [63:0]     ic2arb_data,
  output logic [3:0]      arb2ic_response,
  output logic [63:0]     arb2ic_data,
  output logic [3:0]      arb2ic_tag,
  input  logic [1:0]      dc2arb_command,
  input  logic [XLEN-1:0] dc2arb_addr,
  input  logic [63:0]     dc2arb_data,
  output logic [3:0]      arb2dc_response,
  output logic [63:0]     arb2dc_data,
  output logic [3:0]      arb2dc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [4:0]      arb_outstanding,
  output logic            arb_tag_error
);

  localparam logic [1:0] c_BUS_NONE = 2'd0;
  localparam logic [1:0] c_BUS_LOAD = 2'd1;
  localparam logic [3:0] c_MAX_TAG  = 4'(NUM_TAGS);
  localparam logic [4:0] c_MAX_OUT  = 5'(NUM_TAGS);

  logic            r_last_grant;  // 0 = ic, 1 = dc
  logic [4:0]      r_outstanding;
  logic            r_tag_error;

  logic            w_ic_req;
  logic            w_dc_req;
  logic            w_any_req;
  logic            w_grant_dc;
  logic [1:0]      w_cmd;
  logic [XLEN-1:0] w_addr;
  logic [63:0]     w_data;
  logic            w_accepted;
  logic            w_load_acc;
  logic [15:0]     w_valid_vec;
  logic [15:0]     w_id_vec;
  logic            w_ret_valid;
  logic            w_ret_unknown;
  logic            w_ret_dc;

  assign w_ic_req  = (ic2arb_command != c_BUS_NONE);
  assign w_dc_req  = (dc2arb_command != c_BUS_NONE);
  assign w_any_req = w_ic_req | w_dc_req;

  // On a tie the requester that did not win last time gets the bus.
  always_comb begin
    w_grant_dc = w_dc_req;
    if (w_ic_req && w_dc_req) begin
      w_grant_dc = ~r_last_grant;
    end
  end

  always_comb begin
    w_cmd  = c_BUS_NONE;
    w_addr = '0;
    w_data = '0;
    if (w_grant_dc) begin
      w_cmd  = dc2arb_command;
      w_addr = dc2arb_addr;
      w_data = dc2arb_data;
    end else if (w_ic_req) begin
      w_cmd  = ic2arb_command;
      w_addr = ic2arb_addr;
      w_data = ic2arb_data;
    end
  end

  assign w_accepted = w_any_req && (mem2proc_response != 4'd0);
  assign w_load_acc = w_accepted && (w_cmd == c_BUS_LOAD) &&
                      (mem2proc_response <= c_MAX_TAG);

  assign w_ret_valid   = (mem2proc_tag != 4'd0) &&  w_valid_vec[mem2proc_tag];
  assign w_ret_unknown = (mem2proc_tag != 4'd0) && !w_valid_vec[mem2proc_tag];
  assign w_ret_dc      = w_id_vec[mem2proc_tag];

  // Owner table; allocate takes precedence over a same-cycle free of the same tag.
  for (genvar i = 0; i < 16; i++) begin : g_entry
    if (i >= 1 && i <= NUM_TAGS) begin : g_live
      logic r_valid;
      logic r_id;
      always_ff @(posedge clock) begin
        if (reset) begin
          r_valid <= 1'b0;
          r_id    <= 1'b0;
        end else if (w_load_acc && (mem2proc_response == 4'(i))) begin
          r_valid <= 1'b1;
          r_id    <= w_grant_dc;
        end else if (w_ret_valid && (mem2proc_tag == 4'(i))) begin
          r_valid <= 1'b0;
        end
      end
      assign w_valid_vec[i] = r_valid;
      assign w_id_vec[i]    = r_id;
    end else begin : g_tied
      assign w_valid_vec[i] = 1'b0;
      assign w_id_vec[i]    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_grant  <= 1'b0;
      r_outstanding <= 5'd0;
      r_tag_error   <= 1'b0;
    end else begin
      if (w_accepted) begin
        r_last_grant <= w_grant_dc;
      end
      if (w_load_acc && !w_ret_valid && (r_outstanding < c_MAX_OUT)) begin
        r_outstanding <= r_outstanding + 5'd1;
      end else if (w_ret_valid && !w_load_acc && (r_outstanding != 5'd0)) begin
        r_outstanding <= r_outstanding - 5'd1;
      end
      if (w_ret_unknown) begin
        r_tag_error <= 1'b1;
      end
    end
  end

  assign proc2mem_command = reset ? c_BUS_NONE : w_cmd;
  assign proc2mem_addr    = reset ? '0 : w_addr;
  assign proc2mem_data    = reset ? '0 : w_data;

  assign arb2ic_response = (reset || !w_ic_req || w_grant_dc) ? 4'd0 : mem2proc_response;
  assign arb2dc_response = (reset || !w_grant_dc) ? 4'd0 : mem2proc_response;

  assign arb2ic_tag  = (!reset && w_ret_valid && !w_ret_dc) ? mem2proc_tag : 4'd0;
  assign arb2dc_tag  = (!reset && w_ret_valid &&  w_ret_dc) ? mem2proc_tag : 4'd0;
  assign arb2ic_data = reset ? 64'd0 : mem2proc_data;
  assign arb2dc_data = reset ? 64'd0 : mem2proc_data;

  assign arb_outstanding = r_outstanding;
  assign arb_tag_error   = r_tag_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed self-checking bench for mem_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

  localparam logic [1:0] c_NONE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_STORE = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  ic2arb_command, dc2arb_command;
  logic [31:0] ic2arb_addr, dc2arb_addr;
  logic [63:0] ic2arb_data, dc2arb_data;
  logic [3:0]  arb2ic_response, arb2ic_tag, arb2dc_response, arb2dc_tag;
  logic [63:0] arb2ic_data, arb2dc_data;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic [4:0]  arb_outstanding;
  logic        arb_tag_error;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.XLEN(32), .NUM_TAGS(15)) dut (
    .clock(clock), .reset(reset),
    .ic2arb_command(ic2arb_command), .ic2arb_addr(ic2arb_addr), .ic2arb_data(ic2arb_data),
    .arb2ic_response(arb2ic_response), .arb2ic_data(arb2ic_data), .arb2ic_tag(arb2ic_tag),
    .dc2arb_command(dc2arb_command), .dc2arb_addr(dc2arb_addr), .dc2arb_data(dc2arb_data),
    .arb2dc_response(arb2dc_response), .arb2dc_data(arb2dc_data), .arb2dc_tag(arb2dc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .arb_outstanding(arb_outstanding), .arb_tag_error(arb_tag_error)
  );

  always #5 clock = ~clock;

  task automatic idle_inputs();
    ic2arb_command = c_NONE; ic2arb_addr = '0; ic2arb_data = '0;
    dc2arb_command = c_NONE; dc2arb_addr = '0; dc2arb_data = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    ic2arb_command = c_LOAD; ic2arb_addr = 32'h10;
    dc2arb_command = c_LOAD; dc2arb_addr = 32'h20;
    mem2proc_response = 4'd3; mem2proc_tag = 4'd5; mem2proc_data = 64'hABCD;
    #1;
    checks++; if (proc2mem_command !== c_NONE) begin errors++; $display("FAIL rst_cmd got %0h exp 0", proc2mem_command); end
    checks++; if (proc2mem_addr !== 32'd0) begin errors++; $display("FAIL rst_addr got %0h exp 0", proc2mem_addr); end
    checks++; if (arb2ic_response !== 4'd0 || arb2dc_response !== 4'd0) begin errors++; $display("FAIL rst_resp got ic %0d dc %0d exp 0 0", arb2ic_response, arb2dc_response); end
    checks++; if (arb2ic_tag !== 4'd0 || arb2dc_tag !== 4'd0) begin errors++; $display("FAIL rst_tag got ic %0d dc %0d exp 0 0", arb2ic_tag, arb2dc_tag); end
    checks++; if (arb2ic_data !== 64'd0 || arb2dc_data !== 64'd0) begin errors++; $display("FAIL rst_data got ic %0h dc %0h exp 0 0", arb2ic_data, arb2dc_data); end
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    checks++; if (arb_outstanding !== 5'd0) begin errors++; $display("FAIL rst_outstanding got %0d exp 0", arb_outstanding); end
    checks++; if (arb_tag_error !== 1'b0) begin errors++; $display("FAIL rst_tag_error got %0b exp 0", arb_tag_error); end
  endtask

  task automatic test_icache_only();
    apply_reset();
    ic2arb_command = c_LOAD; ic2arb_addr = 32'h100; mem2proc_response = 4'd3;
    #1;
    checks++; if (proc2mem_command !== c_LOAD || proc2mem_addr !== 32'h100) begin errors++; $display("FAIL ic_bus got cmd %0h addr %0h exp 1 100", proc2mem_command, proc2mem_addr); end
    checks++; if (arb2ic_response !== 4'd3 || arb2dc_response !== 4'd0) begin errors++; $display("FAIL ic_resp got ic %0d dc %0d exp 3 0", arb2ic_response, arb2dc_response); end
    @(negedge clock);
    idle_inputs();
    checks++; if (arb_outstanding !== 5'd1) begin errors++; $display("FAIL ic_out1 got %0d exp 1", arb_outstanding); end
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD;
    #1;
    checks++; if (arb2ic_tag !== 4'd3 || arb2ic_data !== 64'hDEAD) begin errors++; $display("FAIL ic_ret got tag %0d data %0h exp 3 dead", arb2ic_tag, arb2ic_data); end
    checks++; if (arb2dc_tag !== 4'd0) begin errors++; $display("FAIL ic_ret_dc got %0d exp 0", arb2dc_tag); end
    @(negedge clock);
    idle_inputs();
    checks++; if (arb_outstanding !== 5'd0) begin errors++; $display("FAIL ic_out0 got %0d exp 0", arb_outstanding); end
    checks++; if (arb_tag_error !== 1'b0) begin errors++; $display("FAIL ic_err got %0b exp 0", arb_tag_error); end
  endtask

  task automatic test_round_robin();
    logic [3:0] t;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clock);
      t = 4'(i + 1);
      ic2arb_command = c_LOAD; ic2arb_addr = 32'h300;
      dc2arb_command = c_LOAD; dc2arb_addr = 32'h200;
      mem2proc_response = t;
      #1;
      if (i % 2 == 0) begin
        checks++; if (arb2dc_response !== t || arb2ic_response !== 4'd0 || proc2mem_addr !== 32'h200) begin errors++; $display("FAIL rr_grant%0d got dc %0d ic %0d addr %0h exp dc grant", i, arb2dc_response, arb2ic_response, proc2mem_addr); end
      end else begin
        checks++; if (arb2ic_response !== t || arb2dc_response !== 4'd0 || proc2mem_addr !== 32'h300) begin errors++; $display("FAIL rr_grant%0d got dc %0d ic %0d addr %0h exp ic grant", i, arb2dc_response, arb2ic_response, proc2mem_addr); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) begin
        checks++; if (arb_outstanding !== 5'd4) begin errors++; $display("FAIL rr_out4 got %0d exp 4", arb_outstanding); end
      end
      idle_inputs();
      t = 4'(i + 1);
      mem2proc_tag = t; mem2proc_data = 64'h1000 + 64'(i);
      #1;
      if (i % 2 == 0) begin
        checks++; if (arb2dc_tag !== t || arb2ic_tag !== 4'd0 || arb2dc_data !== 64'h1000 + 64'(i)) begin errors++; $display("FAIL rr_ret%0d got dc %0d ic %0d exp dc %0d", i, arb2dc_tag, arb2ic_tag, t); end
      end else begin
        checks++; if (arb2ic_tag !== t || arb2dc_tag !== 4'd0 || arb2ic_data !== 64'h1000 + 64'(i)) begin errors++; $display("FAIL rr_ret%0d got dc %0d ic %0d exp ic %0d", i, arb2dc_tag, arb2ic_tag, t); end
      end
    end
    @(negedge clock);
    idle_inputs();
    checks++; if (arb_outstanding !== 5'd0) begin errors++; $display("FAIL rr_out0 got %0d exp 0", arb_outstanding); end
  endtask

  task automatic test_reject_stall();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clock);
      ic2arb_command = c_LOAD; ic2arb_addr = 32'h300;
      dc2arb_command = c_LOAD; dc2arb_addr = 32'h200;
      mem2proc_response = (i == 3) ? 4'd5 : 4'd0;
      #1;
      checks++; if (proc2mem_addr !== 32'h200 || arb2ic_response !== 4'd0 || arb2dc_response !== mem2proc_response) begin errors++; $display("FAIL rej_cycle%0d got addr %0h ic %0d dc %0d exp addr 200 ic 0", i, proc2mem_addr, arb2ic_response, arb2dc_response); end
    end
    @(negedge clock);
    mem2proc_response = 4'd6;
    #1;
    checks++; if (arb2ic_response !== 4'd6 || arb2dc_response !== 4'd0 || proc2mem_addr !== 32'h300) begin errors++; $display("FAIL rej_flip got ic %0d dc %0d addr %0h exp 6 0 300", arb2ic_response, arb2dc_response, proc2mem_addr); end
    @(negedge clock);
    idle_inputs();
    checks++; if (arb_outstanding !== 5'd2) begin errors++; $display("FAIL rej_out got %0d exp 2", arb_outstanding); end
  endtask

  task automatic test_store_unknown();
    apply_reset();
    dc2arb_command = c_STORE; dc2arb_addr = 32'h40; dc2arb_data = 64'h1234; mem2proc_response = 4'd7;
    #1;
    checks++; if (proc2mem_command !== c_STORE || proc2mem_data !== 64'h1234 || arb2dc_response !== 4'd7) begin errors++; $display("FAIL st_bus got cmd %0h data %0h resp %0d exp 2 1234 7", proc2mem_command, proc2mem_data, arb2dc_response); end
    @(negedge clock);
    idle_inputs();
    checks++; if (arb_outstanding !== 5'd0) begin errors++; $display("FAIL st_out got %0d exp 0", arb_outstanding); end
    mem2proc_tag = 4'd7; mem2proc_data = 64'h77;
    #1;
    checks++; if (arb2ic_tag !== 4'd0 || arb2dc_tag !== 4'd0) begin errors++; $display("FAIL st_ret got ic %0d dc %0d exp 0 0", arb2ic_tag, arb2dc_tag); end
    @(negedge clock);
    idle_inputs();
    checks++; if (arb_tag_error !== 1'b1) begin errors++; $display("FAIL st_err got %0b exp 1", arb_tag_error); end
  endtask

  task automatic test_same_tag_reuse();
    apply_reset();
    dc2arb_command = c_LOAD; dc2arb_addr = 32'h80; mem2proc_response = 4'd2;
    @(negedge clock);
    idle_inputs();
    ic2arb_command = c_LOAD; ic2arb_addr = 32'h90; mem2proc_response = 4'd2;
    mem2proc_tag = 4'd2; mem2proc_data = 64'hBEEF;
    #1;
    checks++; if (arb2dc_tag !== 4'd2 || arb2ic_tag !== 4'd0 || arb2ic_response !== 4'd2) begin errors++; $display("FAIL reuse_same got dc %0d ic %0d icresp %0d exp 2 0 2", arb2dc_tag, arb2ic_tag, arb2ic_response); end
    @(negedge clock);
    idle_inputs();
    checks++; if (arb_outstanding !== 5'd1) begin errors++; $display("FAIL reuse_out got %0d exp 1", arb_outstanding); end
    mem2proc_tag = 4'd2; mem2proc_data = 64'h55;
    #1;
    checks++; if (arb2ic_tag !== 4'd2 || arb2dc_tag !== 4'd0) begin errors++; $display("FAIL reuse_owner got ic %0d dc %0d exp 2 0", arb2ic_tag, arb2dc_tag); end
    @(negedge clock);
    idle_inputs();
    checks++; if (arb_outstanding !== 5'd0 || arb_tag_error !== 1'b0) begin errors++; $display("FAIL reuse_end got out %0d err %0b exp 0 0", arb_outstanding, arb_tag_error); end
  endtask

  task automatic test_full_then_reset();
    apply_reset();
    for (int i = 1; i <= 15; i++) begin
      if (i != 1) @(negedge clock);
      dc2arb_command = c_LOAD; dc2arb_addr = 32'(i * 8); mem2proc_response = 4'(i);
    end
    @(negedge clock);
    idle_inputs();
    checks++; if (arb_outstanding !== 5'd15) begin errors++; $display("FAIL full_out got %0d exp 15", arb_outstanding); end
    reset = 1'b1;
    ic2arb_command = c_LOAD; ic2arb_addr = 32'h300;
    dc2arb_command = c_LOAD; dc2arb_addr = 32'h200;
    mem2proc_response = 4'd4;
    #1;
    checks++; if (proc2mem_command !== c_NONE || arb2dc_response !== 4'd0 || arb2ic_response !== 4'd0) begin errors++; $display("FAIL full_rst got cmd %0h dc %0d ic %0d exp 0 0 0", proc2mem_command, arb2dc_response, arb2ic_response); end
    @(negedge clock);
    reset = 1'b0;
    mem2proc_response = 4'd1;
    checks++; if (arb_outstanding !== 5'd0) begin errors++; $display("FAIL full_rst_out got %0d exp 0", arb_outstanding); end
    #1;
    checks++; if (arb2dc_response !== 4'd1 || arb2ic_response !== 4'd0) begin errors++; $display("FAIL full_tie got dc %0d ic %0d exp 1 0", arb2dc_response, arb2ic_response); end
    @(negedge clock);
    idle_inputs();
    mem2proc_tag = 4'd9;
    #1;
    checks++; if (arb2dc_tag !== 4'd0 || arb2ic_tag !== 4'd0) begin errors++; $display("FAIL full_stale got dc %0d ic %0d exp 0 0", arb2dc_tag, arb2ic_tag); end
    @(negedge clock);
    idle_inputs();
    checks++; if (arb_tag_error !== 1'b1) begin errors++; $display("FAIL full_err got %0b exp 1", arb_tag_error); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    test_reset();
    test_icache_only();
    test_round_robin();
    test_reject_stall();
    test_store_unknown();
    test_same_tag_reuse();
    test_full_then_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
